// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: FSM state encoding and
// the IR FunSel codes used to load the low and high instruction bytes.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [2:0] FS_LOAD_LO = 3'b101;
    localparam logic [2:0] FS_LOAD_HI = 3'b110;
    localparam logic [2:0] FS_HOLD    = 3'b000;

    function automatic logic is_fetch(input state_t s);
        return (s == FETCH_LO) || (s == FETCH_HI);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its control unit, byte memory and the IR.
// Handshake: a byte transfers on a rising edge where MemReq=1 and MemAck=1; MemReq
// stays high (MemAddr stable) until that edge, and MemAck is ignored while MemReq=0.
interface fetch_sequencer_if;

    logic        Start;
    logic        PcLoad;
    logic [15:0] PcIn;
    logic        MemAck;
    logic [7:0]  MemData;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic [15:0] IR_I;
    logic        IR_E;
    logic [2:0]  IR_FunSel;
    logic        Busy;
    logic        Done;
    logic        Fault;

    modport master (
        input  Start, PcLoad, PcIn, MemAck, MemData,
        output MemReq, MemAddr, IR_I, IR_E, IR_FunSel, Busy, Done, Fault
    );

    modport slave (
        output Start, PcLoad, PcIn, MemAck, MemData,
        input  MemReq, MemAddr, IR_I, IR_E, IR_FunSel, Busy, Done, Fault
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch into the 16-bit IR; owns the program counter.
// Optional FETCH_TIMEOUT_EN adds a MemAck wait timeout with Fault pulse and PC restore.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          TIMEOUT_CYC = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    fetch_sequencer_if.master bus,
    output state_t            DbgState
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 16) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYC must be in 1..16");
    end

    state_t      state, state_nx;
    logic [15:0] pc, pc_nx, pc_restore;
    logic        timeout;

    logic        mem_req_q, mem_req_nx;
    logic [15:0] ir_i_q, ir_i_nx;
    logic        ir_e_q, ir_e_nx;
    logic [2:0]  fs_q, fs_nx;
    logic        done_q, done_nx;
    logic        busy;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            mem_req_q <= 1'b0;
            ir_i_q    <= 16'h0000;
            ir_e_q    <= 1'b0;
            fs_q      <= FS_HOLD;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            mem_req_q <= mem_req_nx;
            ir_i_q    <= ir_i_nx;
            ir_e_q    <= ir_e_nx;
            fs_q      <= fs_nx;
            done_q    <= done_nx;
        end
    end

    // PC moves with the FSM: load only in IDLE, +1 per accepted byte (wraps mod 2^16).
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            IDLE: begin
                if (bus.PcLoad) pc_nx = bus.PcIn;
                if (bus.Start)  state_nx = FETCH_LO;
            end
            FETCH_LO: begin
                if (bus.MemAck) begin
                    state_nx = FETCH_HI;
                    pc_nx    = pc + 16'd1;
                end else if (timeout) begin
                    state_nx = IDLE;
                    pc_nx    = pc_restore;
                end
            end
            FETCH_HI: begin
                if (bus.MemAck) begin
                    state_nx = DONE;
                    pc_nx    = pc + 16'd1;
                end else if (timeout) begin
                    state_nx = IDLE;
                    pc_nx    = pc_restore;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req_nx = is_fetch(state_nx);
        ir_e_nx    = 1'b0;
        fs_nx      = FS_HOLD;
        ir_i_nx    = ir_i_q;
        done_nx    = (state == DONE);
        busy       = (state != IDLE);
        if (is_fetch(state) && bus.MemAck) begin
            ir_e_nx = 1'b1;
            fs_nx   = (state == FETCH_LO) ? FS_LOAD_LO : FS_LOAD_HI;
            ir_i_nx = {8'h00, bus.MemData};
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYC - 1);

    logic [3:0]  wait_cnt;
    logic [15:0] pc_start;
    logic        fault_q;

    // An ack on the expiry edge wins because timeout requires MemAck=0.
    assign timeout    = is_fetch(state) && !bus.MemAck && (wait_cnt == WAIT_LAST);
    assign pc_restore = pc_start;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt <= 4'd0;
            pc_start <= RESET_PC;
            fault_q  <= 1'b0;
        end else begin
            fault_q <= timeout;
            if ((state_nx != state) || bus.MemAck) begin
                wait_cnt <= 4'd0;
            end else if (mem_req_q) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if ((state == IDLE) && bus.Start) pc_start <= pc_nx;
        end
    end

    assign bus.Fault = fault_q;
`else
    assign timeout    = 1'b0;
    assign pc_restore = pc;
    assign bus.Fault  = 1'b0;
`endif

    assign bus.MemReq    = mem_req_q;
    assign bus.MemAddr   = pc;
    assign bus.IR_I      = ir_i_q;
    assign bus.IR_E      = ir_e_q;
    assign bus.IR_FunSel = fs_q;
    assign bus.Busy      = busy;
    assign bus.Done      = done_q;
    assign DbgState      = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte-memory responder with programmable ack
// delay, scoreboard queues for IR loads and Done/PC, timeout case under FETCH_TIMEOUT_EN.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic   Clock;
    logic   Reset;
    state_t DbgState;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC    (16'h0000),
        .TIMEOUT_CYC (15)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .bus      (bus),
        .DbgState (DbgState)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_ir_q[$];
    logic [15:0] exp_done_q[$];
    logic [18:0] ir_exp;
    logic [15:0] done_exp;

    logic [7:0] mem [0:65535];
    int ack_delay = 0;
    int resp_cnt  = 0;
    logic ack_never = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte memory: acks after ack_delay idle request cycles, data from mem[MemAddr].
    always @(negedge Clock) begin
        if (Reset || !bus.MemReq) begin
            resp_cnt   = 0;
            bus.MemAck = 1'b0;
        end else if (!ack_never && resp_cnt >= ack_delay) begin
            bus.MemAck  = 1'b1;
            bus.MemData = mem[bus.MemAddr];
            resp_cnt    = 0;
        end else begin
            bus.MemAck = 1'b0;
            resp_cnt++;
        end
    end

    // Monitor: every IR load and every Done pulse consumes one expectation.
    always @(negedge Clock) begin
        if (bus.IR_E) begin
            if (exp_ir_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ir_unexpected: got funsel %b data %h, expected no load", bus.IR_FunSel, bus.IR_I);
            end else begin
                ir_exp = exp_ir_q.pop_front();
                check("ir_load", {13'd0, bus.IR_FunSel, bus.IR_I}, {13'd0, ir_exp});
            end
        end else begin
            check("funsel_hold", {29'd0, bus.IR_FunSel}, {29'd0, FS_HOLD});
        end
        if (bus.Done) begin
            if (exp_done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got Done=1 pc %h, expected no Done", bus.MemAddr);
            end else begin
                done_exp = exp_done_q.pop_front();
                check("done_pc", {16'd0, bus.MemAddr}, {16'd0, done_exp});
            end
        end
`ifndef FETCH_TIMEOUT_EN
        check("fault_tied", {31'd0, bus.Fault}, 32'd0);
`endif
    end

    // Called at a negedge with the DUT idle; returns at the negedge where Done is seen.
    task automatic run_fetch(input logic [15:0] addr, input logic load, input logic [7:0] lo,
                             input logic [7:0] hi, input logic [15:0] pc_end, input int exp_lat,
                             input logic poke);
        int lat;
        logic seen;
        exp_ir_q.push_back({FS_LOAD_LO, 8'h00, lo});
        exp_ir_q.push_back({FS_LOAD_HI, 8'h00, hi});
        exp_done_q.push_back(pc_end);
        bus.Start  = 1'b1;
        bus.PcLoad = load;
        bus.PcIn   = addr;
        @(posedge Clock);
        @(negedge Clock);
        bus.Start  = 1'b0;
        bus.PcLoad = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(posedge Clock);
            lat++;
            @(negedge Clock);
            if (poke && lat == 1) begin
                check("wait_req", {31'd0, bus.MemReq}, 32'd1);
                check("wait_addr1", {16'd0, bus.MemAddr}, {16'd0, addr});
                bus.Start  = 1'b1;
                bus.PcLoad = 1'b1;
                bus.PcIn   = 16'h4000;
            end else if (poke && lat == 2) begin
                check("wait_addr2", {16'd0, bus.MemAddr}, {16'd0, addr});
                bus.Start  = 1'b0;
                bus.PcLoad = 1'b0;
            end
            seen = bus.Done;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", lat, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        mem[16'h0012] = 8'h78; mem[16'h0013] = 8'h56;
        mem[16'h0014] = 8'hBC; mem[16'h0015] = 8'h9A;
        mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
        mem[16'h0001] = 8'hEF; mem[16'h0002] = 8'h66;
        mem[16'h0003] = 8'h21;

        Reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.PcLoad = 1'b0;
        bus.PcIn   = 16'h0000;
        bus.MemAck = 1'b0;
        bus.MemData = 8'h00;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_state", 32'(DbgState), 32'(IDLE));
        check("rst_pc", {16'd0, bus.MemAddr}, 32'h0000);
        check("rst_memreq", {31'd0, bus.MemReq}, 32'd0);
        check("rst_ir_e", {31'd0, bus.IR_E}, 32'd0);
        check("rst_ir_i", {16'd0, bus.IR_I}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_done", {31'd0, bus.Done}, 32'd0);
        check("rst_fault", {31'd0, bus.Fault}, 32'd0);
        Reset = 1'b0;

        // PC load alone in IDLE, then zero-wait fetch and a back-to-back one
        bus.PcLoad = 1'b1;
        bus.PcIn   = 16'h0010;
        @(posedge Clock);
        @(negedge Clock);
        bus.PcLoad = 1'b0;
        check("load_pc", {16'd0, bus.MemAddr}, 32'h0010);
        check("load_busy", {31'd0, bus.Busy}, 32'd0);
        run_fetch(16'h0010, 1'b0, 8'h34, 8'h12, 16'h0012, 3, 1'b0);
        run_fetch(16'h0012, 1'b0, 8'h78, 8'h56, 16'h0014, 3, 1'b0);

        // Two-cycle ack delay, with Start/PcLoad poked while in FETCH_LO
        ack_delay = 2;
        run_fetch(16'h0014, 1'b0, 8'hBC, 8'h9A, 16'h0016, 7, 1'b1);
        ack_delay = 0;
        repeat (5) @(negedge Clock);
        check("post_poke_busy", {31'd0, bus.Busy}, 32'd0);
        check("post_poke_pc", {16'd0, bus.MemAddr}, 32'h0016);

        // Start with PcLoad at 0xFFFF: high byte from 0x0000, PC ends at 0x0001
        run_fetch(16'hFFFF, 1'b1, 8'hCD, 8'hAB, 16'h0001, 3, 1'b0);

        // Reset while in FETCH_HI: only the low byte reaches the IR
        ack_delay = 2;
        exp_ir_q.push_back({FS_LOAD_LO, 8'h00, 8'hEF});
        bus.Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (3) begin
            @(posedge Clock);
            @(negedge Clock);
        end
        check("pre_rst_state", 32'(DbgState), 32'(FETCH_HI));
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check("midrst_state", 32'(DbgState), 32'(IDLE));
        check("midrst_memreq", {31'd0, bus.MemReq}, 32'd0);
        check("midrst_pc", {16'd0, bus.MemAddr}, 32'h0000);
        check("midrst_ir_e", {31'd0, bus.IR_E}, 32'd0);
        Reset = 1'b0;
        ack_delay = 0;
        repeat (4) @(negedge Clock);
        check("postrst_busy", {31'd0, bus.Busy}, 32'd0);

        run_fetch(16'h0000, 1'b0, 8'hAB, 8'hEF, 16'h0002, 3, 1'b0);
        run_fetch(16'h0002, 1'b0, 8'h66, 8'h21, 16'h0004, 3, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        begin
            int lat;
            ack_never = 1'b1;
            bus.Start = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
            bus.Start = 1'b0;
            lat = 0;
            while (!bus.Fault && lat < 64) begin
                @(posedge Clock);
                lat++;
                @(negedge Clock);
            end
            check("to_fault", {31'd0, bus.Fault}, 32'd1);
            check("to_latency", lat, 15);
            check("to_state", 32'(DbgState), 32'(IDLE));
            check("to_pc", {16'd0, bus.MemAddr}, 32'h0004);
            check("to_memreq", {31'd0, bus.MemReq}, 32'd0);
            @(negedge Clock);
            check("to_fault_pulse", {31'd0, bus.Fault}, 32'd0);
            ack_never = 1'b0;
        end
`endif

        repeat (3) @(negedge Clock);
        check("ir_queue_empty", exp_ir_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
